// File: rtl/wtm_pkg.sv
// Shared constants and state encoding for the Wallace-tree multiplier datapath
// and its downstream dot-product accumulator.
package wtm_pkg;

  localparam int unsigned PROD_W    = 16;
  localparam int unsigned ACC_W_DEF = 24;
  localparam int unsigned LEN_DEF   = 8;
  localparam int unsigned CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_e;

endpackage : wtm_pkg

// File: rtl/wtm8_dot_accum_if.sv
// Product-in / result-out handshake bundle for the dot-product accumulator.
interface wtm8_dot_accum_if
  import wtm_pkg::*;
#(
  parameter int unsigned P_W = PROD_W,
  parameter int unsigned A_W = ACC_W_DEF
);

  logic [P_W-1:0] prod_in;
  logic           in_valid;
  logic           in_ready;
  logic [A_W-1:0] acc_out;
  logic           acc_ovf;
  logic           out_valid;
  logic           out_ready;
  logic           busy;

  modport slave (
    input  prod_in, in_valid, out_ready,
    output in_ready, acc_out, acc_ovf, out_valid, busy
  );

  modport master (
    output prod_in, in_valid, out_ready,
    input  in_ready, acc_out, acc_ovf, out_valid, busy
  );

endinterface : wtm8_dot_accum_if

// File: rtl/wtm8_dot_accum.sv
// Sums LEN consecutive multiplier products into one dot-product result with a
// sticky carry-out flag; result handshake allows zero-bubble back-to-back sums.
module wtm8_dot_accum
  import wtm_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned LEN   = LEN_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  wtm8_dot_accum_if.slave    bus
);

  acc_state_e       state_q;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic             out_valid_q;

  logic             accept;
  logic [ACC_W:0]   sum_d;
  logic             last_term;

  // Input is blocked while in reset or during a clear cycle so no beat is half-taken.
  assign bus.in_ready = rst_n && !clear &&
                        ((state_q != HOLD) || bus.out_ready);
  assign bus.busy     = (state_q == ACCUM);
  assign accept       = bus.in_valid && bus.in_ready;

  assign sum_d     = {1'b0, acc_q} + (ACC_W+1)'(bus.prod_in);
  assign last_term = (cnt_q == CNT_W'(LEN - 1));

  assign bus.acc_out   = acc_q;
  assign bus.acc_ovf   = ovf_q;
  assign bus.out_valid = out_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (clear) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            acc_q       <= ACC_W'(bus.prod_in);
            cnt_q       <= CNT_W'(1);
            ovf_q       <= 1'b0;
            state_q     <= (LEN == 1) ? HOLD : ACCUM;
            out_valid_q <= (LEN == 1);
          end
        end
        ACCUM: begin
          if (accept) begin
            acc_q <= sum_d[ACC_W-1:0];
            cnt_q <= cnt_q + CNT_W'(1);
            ovf_q <= ovf_q | sum_d[ACC_W];
            if (last_term) begin
              state_q     <= HOLD;
              out_valid_q <= 1'b1;
            end
          end
        end
        HOLD: begin
          // A beat accepted alongside the result handshake opens the next sum.
          if (bus.out_ready) begin
            if (accept) begin
              acc_q       <= ACC_W'(bus.prod_in);
              cnt_q       <= CNT_W'(1);
              ovf_q       <= 1'b0;
              state_q     <= (LEN == 1) ? HOLD : ACCUM;
              out_valid_q <= (LEN == 1);
            end else begin
              state_q     <= IDLE;
              out_valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule : wtm8_dot_accum

// File: tb/tb_wtm8_dot_accum.sv
// Directed bench for wtm8_dot_accum: four instances cover LEN=4, LEN=2,
// a 16-bit accumulator for carry-out, and LEN=1 streaming.
module tb_wtm8_dot_accum;

  logic clk;
  logic rst_n;
  logic c4, c2, co, c1;

  int unsigned passes;
  int unsigned checks;

  wtm8_dot_accum_if #(.P_W(16), .A_W(24)) b4 ();
  wtm8_dot_accum_if #(.P_W(16), .A_W(24)) b2 ();
  wtm8_dot_accum_if #(.P_W(16), .A_W(16)) bo ();
  wtm8_dot_accum_if #(.P_W(16), .A_W(24)) b1 ();

  wtm8_dot_accum #(.ACC_W(24), .LEN(4), .CNT_W(8)) u4 (
    .clk(clk), .rst_n(rst_n), .clear(c4), .bus(b4.slave));
  wtm8_dot_accum #(.ACC_W(24), .LEN(2), .CNT_W(8)) u2 (
    .clk(clk), .rst_n(rst_n), .clear(c2), .bus(b2.slave));
  wtm8_dot_accum #(.ACC_W(16), .LEN(2), .CNT_W(8)) uo (
    .clk(clk), .rst_n(rst_n), .clear(co), .bus(bo.slave));
  wtm8_dot_accum #(.ACC_W(24), .LEN(1), .CNT_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .clear(c1), .bus(b1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    passes = 0;
    checks = 0;
    rst_n  = 1'b0;
    {c4, c2, co, c1} = 4'b0;
    b4.prod_in = '0; b4.in_valid = 1'b0; b4.out_ready = 1'b1;
    b2.prod_in = '0; b2.in_valid = 1'b0; b2.out_ready = 1'b0;
    bo.prod_in = '0; bo.in_valid = 1'b0; bo.out_ready = 1'b1;
    b1.prod_in = '0; b1.in_valid = 1'b0; b1.out_ready = 1'b1;

    tick();
    tick();
    chk("rst_in_ready", 32'(b4.in_ready), 32'd0);
    chk("rst_out_valid", 32'(b4.out_valid), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(b4.in_ready), 32'd1);

    // Reset mid-sum after three beats
    b4.in_valid = 1'b1; b4.prod_in = 16'd100;
    tick(); tick(); tick();
    b4.in_valid = 1'b0;
    chk("mid_busy", 32'(b4.busy), 32'd1);
    chk("mid_acc", 32'(b4.acc_out), 32'd300);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(b4.out_valid), 32'd0);
    chk("midrst_acc", 32'(b4.acc_out), 32'd0);
    chk("midrst_busy", 32'(b4.busy), 32'd0);
    chk("midrst_in_ready", 32'(b4.in_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 32'(b4.in_ready), 32'd1);

    // LEN=4 sum of four 255*255 products
    b4.in_valid = 1'b1; b4.prod_in = 16'd65025;
    tick();
    chk("len4_first_acc", 32'(b4.acc_out), 32'd65025);
    tick(); tick();
    chk("len4_no_early_valid", 32'(b4.out_valid), 32'd0);
    tick();
    b4.in_valid = 1'b0;
    chk("len4_valid", 32'(b4.out_valid), 32'd1);
    chk("len4_acc", 32'(b4.acc_out), 32'h03F804);
    chk("len4_ovf", 32'(b4.acc_ovf), 32'd0);
    chk("len4_busy_hold", 32'(b4.busy), 32'd0);
    tick();
    chk("len4_valid_drop", 32'(b4.out_valid), 32'd0);
    chk("len4_idle_ready", 32'(b4.in_ready), 32'd1);

    // Back-pressure with LEN=2
    b2.in_valid = 1'b1; b2.prod_in = 16'd3;
    tick();
    b2.prod_in = 16'd5;
    tick();
    b2.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", 32'(b2.in_ready), 32'd0);
      chk("bp_acc", 32'(b2.acc_out), 32'd8);
      chk("bp_valid", 32'(b2.out_valid), 32'd1);
      tick();
    end
    b2.out_ready = 1'b1; b2.in_valid = 1'b1; b2.prod_in = 16'd7;
    #1;
    chk("bp_release_ready", 32'(b2.in_ready), 32'd1);
    tick();
    b2.in_valid = 1'b0;
    chk("bp_next_busy", 32'(b2.busy), 32'd1);
    chk("bp_next_acc", 32'(b2.acc_out), 32'd7);
    chk("bp_next_valid", 32'(b2.out_valid), 32'd0);

    // Carry-out with a 16-bit accumulator, then a clean follow-up sum
    bo.in_valid = 1'b1; bo.prod_in = 16'd65025;
    tick(); tick();
    bo.prod_in = 16'd1;
    chk("ovf_acc", 32'(bo.acc_out), 32'd64514);
    chk("ovf_flag", 32'(bo.acc_ovf), 32'd1);
    chk("ovf_valid", 32'(bo.out_valid), 32'd1);
    tick();
    chk("ovf_b2b_acc", 32'(bo.acc_out), 32'd1);
    chk("ovf_b2b_flag", 32'(bo.acc_ovf), 32'd0);
    chk("ovf_b2b_busy", 32'(bo.busy), 32'd1);
    tick();
    bo.in_valid = 1'b0;
    chk("ovf_next_acc", 32'(bo.acc_out), 32'd2);
    chk("ovf_next_flag", 32'(bo.acc_ovf), 32'd0);
    chk("ovf_next_valid", 32'(bo.out_valid), 32'd1);

    // clear after two beats; the beat offered during clear must survive
    b4.in_valid = 1'b1; b4.prod_in = 16'd10;
    tick();
    b4.prod_in = 16'd20;
    tick();
    chk("clr_pre_acc", 32'(b4.acc_out), 32'd30);
    c4 = 1'b1; b4.prod_in = 16'd1;
    #1;
    chk("clr_in_ready", 32'(b4.in_ready), 32'd0);
    tick();
    c4 = 1'b0;
    chk("clr_acc", 32'(b4.acc_out), 32'd0);
    chk("clr_busy", 32'(b4.busy), 32'd0);
    tick();
    b4.prod_in = 16'd2;
    tick();
    b4.prod_in = 16'd3;
    tick();
    b4.prod_in = 16'd4;
    tick();
    b4.in_valid = 1'b0;
    chk("clr_result", 32'(b4.acc_out), 32'd10);
    chk("clr_valid", 32'(b4.out_valid), 32'd1);

    // LEN=1 continuous stream, no bubbles
    b1.in_valid = 1'b1;
    for (int v = 1; v <= 3; v++) begin
      b1.prod_in = 16'(v);
      #1;
      chk("len1_in_ready", 32'(b1.in_ready), 32'd1);
      tick();
      chk("len1_valid", 32'(b1.out_valid), 32'd1);
      chk("len1_acc", 32'(b1.acc_out), 32'(v));
    end
    b1.in_valid = 1'b0;
    tick();
    chk("len1_drain", 32'(b1.out_valid), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule : tb_wtm8_dot_accum
